// File: rtl/axi_llc_tag_req_sched.sv
// Tag-store request scheduler: one power-up BIST request, then fair round-robin
// between lookup descriptors and per-line flush sweeps into one registered output stage.
module axi_llc_tag_req_sched #(
    parameter int unsigned SetAssociativity = 8,
    parameter int unsigned IndexLength      = 7,
    parameter int unsigned TagLength        = 20
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [SetAssociativity-1:0] spm_lock_i,
    input  logic [SetAssociativity-1:0] flushed_i,
    input  logic                        lkp_valid_i,
    output logic                        lkp_ready_o,
    input  logic [IndexLength-1:0]      lkp_index_i,
    input  logic [TagLength-1:0]        lkp_tag_i,
    input  logic                        lkp_dirty_i,
    input  logic                        flush_valid_i,
    output logic                        flush_ready_o,
    input  logic [SetAssociativity-1:0] flush_way_i,
    output logic                        flush_busy_o,
    output logic                        flush_done_o,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [1:0]                  req_mode_o,
    output logic [SetAssociativity-1:0] req_indicator_o,
    output logic [IndexLength-1:0]      req_index_o,
    output logic [TagLength-1:0]        req_tag_o,
    output logic                        req_dirty_o,
    input  logic                        bist_valid_i,
    input  logic [SetAssociativity-1:0] bist_res_i,
    output logic                        bist_done_o,
    output logic [SetAssociativity-1:0] bist_res_o
);
    // Mode encoding shared with the tag store.
    localparam logic [1:0] ModeBist   = 2'b00;
    localparam logic [1:0] ModeLookup = 2'b10;
    localparam logic [1:0] ModeFlush  = 2'b11;

    typedef enum logic [1:0] {BIST_REQ, BIST_WAIT, RUN} state_e;
    state_e state_q;

    logic [SetAssociativity-1:0] lkp_mask, way_q;
    logic [IndexLength-1:0]      cnt_q;
    logic lkp_ok, out_hs, load_en, sweep_pend, lkp_grant, flush_grant, flush_accept;
    logic rr_flush_q, busy_q, issued_q, last_q, zero_done_q, last_hs;

    assign lkp_mask     = ~(spm_lock_i | flushed_i);
    assign lkp_ok       = |lkp_mask;
    assign out_hs       = req_valid_o & req_ready_i;
    assign load_en      = (state_q == RUN) & (~req_valid_o | req_ready_i);
    assign sweep_pend   = busy_q & ~issued_q;
    // Ready never looks at lkp_valid_i: when a sweep is pending the pointer alone decides.
    assign lkp_ready_o  = load_en & lkp_ok & (~sweep_pend | ~rr_flush_q);
    assign lkp_grant    = lkp_ready_o & lkp_valid_i;
    assign flush_grant  = load_en & sweep_pend & ~lkp_grant;
    assign flush_ready_o = (state_q == RUN) & ~busy_q;
    assign flush_accept = flush_valid_i & flush_ready_o;
    assign last_hs      = out_hs & last_q;
    assign flush_done_o = last_hs | zero_done_q;
    assign flush_busy_o = busy_q & ~last_hs;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= BIST_REQ;
            req_valid_o     <= 1'b0;
            req_mode_o      <= ModeBist;
            req_indicator_o <= '0;
            req_index_o     <= '0;
            req_tag_o       <= '0;
            req_dirty_o     <= 1'b0;
            last_q          <= 1'b0;
            busy_q          <= 1'b0;
            issued_q        <= 1'b0;
            cnt_q           <= '0;
            way_q           <= '0;
            zero_done_q     <= 1'b0;
            rr_flush_q      <= 1'b0;
            bist_done_o     <= 1'b0;
            bist_res_o      <= '0;
        end else begin
            zero_done_q <= 1'b0;
            if (out_hs) begin
                req_valid_o <= 1'b0;
                last_q      <= 1'b0;
            end
            case (state_q)
                BIST_REQ: begin
                    if (!req_valid_o) begin
                        req_valid_o     <= 1'b1;
                        req_mode_o      <= ModeBist;
                        req_indicator_o <= '1;
                        req_index_o     <= '0;
                        req_tag_o       <= '0;
                        req_dirty_o     <= 1'b0;
                    end else if (req_ready_i) begin
                        state_q <= BIST_WAIT;
                    end
                end
                BIST_WAIT: begin
                    if (bist_valid_i) begin
                        bist_res_o  <= bist_res_i;
                        bist_done_o <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                default: ;
            endcase
            if (lkp_grant) begin
                req_valid_o     <= 1'b1;
                req_mode_o      <= ModeLookup;
                req_indicator_o <= lkp_mask;
                req_index_o     <= lkp_index_i;
                req_tag_o       <= lkp_tag_i;
                req_dirty_o     <= lkp_dirty_i;
                last_q          <= 1'b0;
                rr_flush_q      <= 1'b1;
            end else if (flush_grant) begin
                req_valid_o     <= 1'b1;
                req_mode_o      <= ModeFlush;
                req_indicator_o <= way_q;
                req_index_o     <= cnt_q;
                req_tag_o       <= '0;
                req_dirty_o     <= 1'b0;
                cnt_q           <= cnt_q + 1'b1;
                last_q          <= &cnt_q;
                issued_q        <= &cnt_q;
                rr_flush_q      <= 1'b0;
            end
            if (last_hs) busy_q <= 1'b0;
            // A zero way mask has no lines to sweep; it only produces the done pulse.
            if (flush_accept) begin
                way_q       <= flush_way_i;
                cnt_q       <= '0;
                issued_q    <= 1'b0;
                busy_q      <= |flush_way_i;
                zero_done_q <= ~|flush_way_i;
            end
        end
    end
endmodule
